// File: rtl/weight_tile_loader.sv
// Packs a DATA_WIDTH-bit valid/ready stream into TILE_WIDTH-bit tiles and writes one full weight buffer.
// Optional protocol checking of wbuf_writing_done is enabled by defining WEIGHT_TILE_LOADER_CHECK_EN.
module weight_tile_loader #(
    parameter int BUFFER_WIDTH = 1024,
    parameter int BUFFER_COUNT = 2,
    parameter int TILE_WIDTH   = 256,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [$clog2(BUFFER_COUNT)-1:0] buffer_sel,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            in_ready,
    output logic                            wbuf_write_enable,
    output logic [TILE_WIDTH-1:0]           wbuf_write_data,
    output logic [$clog2(BUFFER_COUNT)-1:0] wbuf_write_buffer,
    input  logic                            wbuf_writing_done,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int TILE_BYTES = TILE_WIDTH / DATA_WIDTH;
    localparam int TILE_COUNT = BUFFER_WIDTH / TILE_WIDTH;
    localparam int ELEM_W     = (TILE_BYTES > 1) ? $clog2(TILE_BYTES) : 1;
    localparam int TCNT_W     = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;
    localparam logic [31:0] LAST_ELEM = 32'(TILE_BYTES - 1);
    localparam logic [31:0] LAST_TILE = 32'(TILE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        WRITE,
        FINISH
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ELEM_W-1:0]   elem_cnt;
    logic [TCNT_W-1:0]   tile_cnt;
    logic [TILE_WIDTH-1:0] tile_sr;
    logic                accept;
    logic                last_elem;
    logic                last_tile;

    assign last_elem = (32'(elem_cnt) == LAST_ELEM);
    assign last_tile = (32'(tile_cnt) == LAST_TILE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        in_ready          = 1'b0;
        wbuf_write_enable = 1'b0;
        busy              = 1'b1;
        done              = 1'b0;
        accept            = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = PACK;
                end
            end
            PACK: begin
                in_ready = 1'b1;
                if (in_valid && last_elem) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wbuf_write_enable = 1'b1;
                state_nxt         = last_tile ? FINISH : PACK;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Elements shift in from the top, so after TILE_BYTES transfers element 0 sits at bits [DATA_WIDTH-1:0].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elem_cnt          <= '0;
            tile_cnt          <= '0;
            tile_sr           <= '0;
            wbuf_write_buffer <= '0;
        end else begin
            if (accept) begin
                wbuf_write_buffer <= buffer_sel;
                elem_cnt          <= '0;
                tile_cnt          <= '0;
            end
            if (in_valid && in_ready) begin
                tile_sr  <= {in_data, tile_sr[TILE_WIDTH-1:DATA_WIDTH]};
                elem_cnt <= elem_cnt + 1'b1;
            end
            if (wbuf_write_enable) begin
                elem_cnt <= '0;
                tile_cnt <= tile_cnt + 1'b1;
            end
        end
    end

    assign wbuf_write_data = tile_sr;

`ifdef WEIGHT_TILE_LOADER_CHECK_EN
    logic err_evt;

    // The buffer file must report completion exactly in the FINISH cycle and never elsewhere.
    assign err_evt = (wbuf_writing_done && (state != FINISH)) ||
                     ((state == FINISH) && !wbuf_writing_done);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error <= 1'b0;
        end else if (err_evt) begin
            error <= 1'b1;
        end else if (accept) begin
            error <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n && err_evt) begin
            $error("weight_tile_loader: wbuf_writing_done out of step with FINISH");
        end
    end
`endif
`else
    logic unused_writing_done;

    assign unused_writing_done = wbuf_writing_done;
    assign error               = 1'b0;
`endif

endmodule
